// File: rtl/cond_unit_pkg.sv
// cond_unit_pkg: shared condition mnemonics and NZCV flag bit positions
package cond_unit_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

endpackage

// File: rtl/cond_unit_check.sv
// cond_check: evaluates an ARM condition field against the NZCV flags
module cond_check
    import cond_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[N_BIT];
    assign z = flags[Z_BIT];
    assign c = flags[C_BIT];
    assign v = flags[V_BIT];

    // condition decode; NV and anything unlisted never execute
    always_comb begin
        cond_ex = 1'b0;
        case (cond_e'(cond))
            EQ: cond_ex = z;
            NE: cond_ex = ~z;
            CS: cond_ex = c;
            CC: cond_ex = ~c;
            MI: cond_ex = n;
            PL: cond_ex = ~n;
            VS: cond_ex = v;
            VC: cond_ex = ~v;
            HI: cond_ex = c & ~z;
            LS: cond_ex = ~c | z;
            GE: cond_ex = n ~^ v;
            LT: cond_ex = n ^ v;
            GT: cond_ex = ~z & (n ~^ v);
            LE: cond_ex = z | (n ^ v);
            AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// cond_unit: NZCV flag register, condition pass and gating of write requests
module cond_unit
    import cond_unit_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       pcs,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       no_write,
    input  logic       stall,
    input  logic       flush,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_write,
    output logic       cond_ex,
    output logic       cond_ex_q,
    output logic [3:0] flags
);

    logic kill, wr_nz, wr_cv;

    // condition is judged on the registered flags only; no forwarding of alu_flags
    cond_check u_check (
        .cond    (cond),
        .flags   (flags),
        .cond_ex (cond_ex)
    );

    assign kill      = flush;
    assign pc_src    = pcs & cond_ex & ~kill;
    assign reg_write = reg_w & ~no_write & cond_ex & ~kill;
    assign mem_write = mem_w & cond_ex & ~kill;
    assign wr_nz     = flag_w[1] & cond_ex & ~stall & ~flush;
    assign wr_cv     = flag_w[0] & cond_ex & ~stall & ~flush;

    // flag groups update independently; cond_ex_q freezes while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags     <= RESET_FLAGS;
            cond_ex_q <= 1'b0;
        end else begin
            if (wr_nz) begin
                flags[N_BIT] <= alu_flags[N_BIT];
                flags[Z_BIT] <= alu_flags[Z_BIT];
            end
            if (wr_cv) begin
                flags[C_BIT] <= alu_flags[C_BIT];
                flags[V_BIT] <= alu_flags[V_BIT];
            end
            if (!stall) cond_ex_q <= cond_ex & ~flush;
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: scoreboard bench for cond_unit against a flag/condition reference model
module tb_cond_unit;

    typedef struct {
        string      tag;
        logic [3:0] flags;
        logic       cond_ex;
        logic       cond_ex_q;
        logic       pc_src;
        logic       reg_write;
        logic       mem_write;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cond = 4'd0;
    logic [3:0] alu_flags = 4'd0;
    logic [1:0] flag_w = 2'd0;
    logic       pcs = 1'b0, reg_w = 1'b0, mem_w = 1'b0, no_write = 1'b0;
    logic       stall = 1'b0, flush = 1'b0;
    logic       pc_src, reg_write, mem_write, cond_ex, cond_ex_q;
    logic [3:0] flags;

    exp_t       q[$];
    event       mon_ev;
    int         n_assert = 0;
    int         n_fail = 0;
    logic [3:0] m_flags = 4'b0000;
    logic       m_q = 1'b0;

    cond_unit dut (
        .clk       (clk),
        .reset     (reset),
        .cond      (cond),
        .alu_flags (alu_flags),
        .flag_w    (flag_w),
        .pcs       (pcs),
        .reg_w     (reg_w),
        .mem_w     (mem_w),
        .no_write  (no_write),
        .stall     (stall),
        .flush     (flush),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .mem_write (mem_write),
        .cond_ex   (cond_ex),
        .cond_ex_q (cond_ex_q),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    // conditions come in pairs: odd codes are the inverse of the even base test
    function automatic logic ref_pass(logic [3:0] c, logic [3:0] f);
        bit n = f[3], z = f[2], cy = f[1], v = f[0];
        bit base;
        if (c == 4'd15) return 1'b0;
        if (c == 4'd14) return 1'b1;
        case (int'(c) / 2)
            0: base = z;
            1: base = cy;
            2: base = n;
            3: base = v;
            4: base = cy && !z;
            5: base = (n == v);
            6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic push_expect(string tag);
        exp_t e;
        bit   p = ref_pass(cond, m_flags);
        e.tag       = tag;
        e.flags     = m_flags;
        e.cond_ex   = p;
        e.cond_ex_q = m_q;
        e.pc_src    = pcs && p && !flush;
        e.reg_write = reg_w && !no_write && p && !flush;
        e.mem_write = mem_w && p && !flush;
        q.push_back(e);
        -> mon_ev;
    endtask

    task automatic model_edge();
        bit p = ref_pass(cond, m_flags);
        bit ok = p && !stall && !flush;
        if (reset) return;
        if (ok && flag_w[1]) m_flags[3:2] = alu_flags[3:2];
        if (ok && flag_w[0]) m_flags[1:0] = alu_flags[1:0];
        if (!stall) m_q = p && !flush;
    endtask

    task automatic step(string tag, input logic [3:0] c, input logic [3:0] af, input logic [1:0] fw,
                        input logic p, input logic rw, input logic mw, input logic nw,
                        input logic st, input logic fl, input logic rs);
        @(negedge clk);
        cond = c; alu_flags = af; flag_w = fw; pcs = p; reg_w = rw; mem_w = mw;
        no_write = nw; stall = st; flush = fl; reset = rs;
        #1;
        if (reset) begin
            m_flags = 4'b0000;
            m_q = 1'b0;
        end
        push_expect(tag);
        model_edge();
    endtask

    // reset pulse wholly between edges while a flag write is requested
    task automatic async_pulse(string tag);
        @(negedge clk);
        cond = 4'b1110; alu_flags = 4'b1111; flag_w = 2'b11;
        pcs = 1'b1; reg_w = 1'b1; mem_w = 1'b1; no_write = 1'b0; stall = 1'b0; flush = 1'b0;
        #1 reset = 1'b1;
        #1;
        m_flags = 4'b0000;
        m_q = 1'b0;
        push_expect(tag);
        #1 reset = 1'b0;
        model_edge();
    endtask

    task automatic chk(string tag, string what, logic [3:0] act, logic [3:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %b expected %b at %0t", tag, what, act, exp, $time);
        end
    endtask

    // monitor: pops each expectation and compares against what the DUT shows now
    initial begin
        exp_t e;
        forever begin
            @(mon_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                chk(e.tag, "flags", flags, e.flags);
                chk(e.tag, "cond_ex", {3'b0, cond_ex}, {3'b0, e.cond_ex});
                chk(e.tag, "cond_ex_q", {3'b0, cond_ex_q}, {3'b0, e.cond_ex_q});
                chk(e.tag, "pc_src", {3'b0, pc_src}, {3'b0, e.pc_src});
                chk(e.tag, "reg_write", {3'b0, reg_write}, {3'b0, e.reg_write});
                chk(e.tag, "mem_write", {3'b0, mem_write}, {3'b0, e.mem_write});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //             tag        cond     alu      fw     p  rw mw nw st fl rs
        step("in_reset",  4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 0, 0, 1);
        step("rst_held",  4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 0, 0, 1);
        step("eq_reset",  4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0, 0);
        step("set_z",     4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0, 0, 0, 0);
        step("eq_pass",   4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0, 0);
        step("cv_only",   4'b1110, 4'b1011, 2'b01, 0, 0, 0, 0, 0, 0, 0);
        step("nz_only",   4'b1110, 4'b1000, 2'b10, 0, 0, 0, 0, 0, 0, 0);
        step("see_1011",  4'b1110, 4'b0000, 2'b00, 0, 1, 0, 1, 0, 0, 0);
        step("set_n",     4'b1110, 4'b1000, 2'b11, 0, 0, 0, 0, 0, 0, 0);
        step("ge_fail",   4'b1010, 4'b0000, 2'b00, 0, 0, 1, 0, 0, 0, 0);
        step("lt_pass",   4'b1011, 4'b0000, 2'b00, 1, 0, 0, 0, 0, 0, 0);
        step("stall",     4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0, 1, 0, 0);
        step("flush",     4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 0, 1, 0);
        step("stl_fls",   4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0, 1, 1, 0);
        step("post_fls",  4'b1110, 4'b0000, 2'b00, 1, 1, 1, 0, 0, 0, 0);
        step("nv",        4'b1111, 4'b1111, 2'b11, 1, 1, 1, 0, 0, 0, 0);
        step("set_all",   4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0, 0, 0, 0);
        step("pre_pulse", 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        async_pulse("pulse");
        step("post_pulse", 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            step($sformatf("rnd%0d", i), 4'($urandom), 4'($urandom), 2'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 40) == 0);
        end
        @(negedge clk);
        #2;
        n_assert++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
